// File: rtl/chipper_flit_injector.sv
// Local-side load-frame initiator for the chipper router: buffers one flit per port and
// plays out N/S/E/W strobes plus a clksig launch. Optional macro: CHIPPER_INJ_HIZ_EN.
module chipper_flit_injector #(
  parameter int DATA_W      = 7,
  parameter int SETUP_CYC   = 1,
  parameter int AUTO_LAUNCH = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_port,
  input  logic [DATA_W-1:0] in_data,
  input  logic              launch_req,
  input  logic              cachemiss,
  output logic [DATA_W-1:0] inc,
  output logic              nsig,
  output logic              ssig,
  output logic              esig,
  output logic              wsig,
  output logic              clksig,
  output logic              busy,
  output logic              frame_done,
  output logic [3:0]        occ
);

  typedef enum logic [3:0] {
    IDLE, N_SETUP, N_STB, S_SETUP, S_STB, E_SETUP, E_STB, W_SETUP, W_STB, LAUNCH
  } state_e;

  localparam logic [3:0] SETUP_M1 = (SETUP_CYC == 0) ? 4'd0 : 4'(SETUP_CYC - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        occ_q, occ_d;
  logic [DATA_W-1:0] slot_q [4];
  logic [DATA_W-1:0] slot_d [4];
  logic [DATA_W-1:0] inc_q, inc_d;
  logic              inc_vld_q, inc_vld_d;
  logic [3:0]        strb_q, strb_d;
  logic              launch_q, launch_d;
  logic              busy_q, busy_d;
  logic [1:0]        port_d;

  function automatic logic [1:0] port_of(input state_e s);
    case (s)
      N_SETUP, N_STB: port_of = 2'd0;
      S_SETUP, S_STB: port_of = 2'd1;
      E_SETUP, E_STB: port_of = 2'd2;
      default:        port_of = 2'd3;
    endcase
  endfunction

  // SETUP_CYC=0 jumps straight into the strobe state of the port.
  function automatic state_e port_entry(input logic [1:0] p);
    if (SETUP_CYC == 0) port_entry = state_e'({1'b0, p, 1'b0} + 4'd2);
    else                port_entry = state_e'({1'b0, p, 1'b0} + 4'd1);
  endfunction

  assign in_ready = (state_q == IDLE) && !occ_q[in_port];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    occ_d   = occ_q;
    slot_d  = slot_q;
    if (in_valid && in_ready) begin
      slot_d[in_port] = in_data;
      occ_d[in_port]  = 1'b1;
    end

    // A strobe or launch state only advances once its pulse has been seen with no stall.
    case (state_q)
      IDLE: begin
        if (launch_req || ((AUTO_LAUNCH != 0) && (&occ_d))) begin
          state_d = port_entry(2'd0);
          cnt_d   = SETUP_M1;
        end
      end
      N_SETUP, S_SETUP, E_SETUP, W_SETUP: begin
        if (!cachemiss) begin
          if (cnt_q == 4'd0) state_d = state_e'(state_q + 4'd1);
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      N_STB, S_STB, E_STB: begin
        if (!cachemiss && (|strb_q)) begin
          state_d = port_entry(port_of(state_q) + 2'd1);
          cnt_d   = SETUP_M1;
        end
      end
      W_STB: begin
        if (!cachemiss && (|strb_q)) state_d = LAUNCH;
      end
      LAUNCH: begin
        if (!cachemiss && launch_q) begin
          state_d = IDLE;
          occ_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    port_d    = port_of(state_d);
    inc_vld_d = (state_d != IDLE) && (state_d != LAUNCH) && occ_d[port_d];
    inc_d     = inc_vld_d ? slot_d[port_d] : '0;
    strb_d    = '0;
    if (!cachemiss && (state_d inside {N_STB, S_STB, E_STB, W_STB})) strb_d[port_d] = 1'b1;
    launch_d  = (state_d == LAUNCH) && !cachemiss;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      occ_q     <= '0;
      slot_q    <= '{default: '0};
      inc_q     <= '0;
      inc_vld_q <= 1'b0;
      strb_q    <= '0;
      launch_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      occ_q     <= occ_d;
      slot_q    <= slot_d;
      inc_q     <= inc_d;
      inc_vld_q <= inc_vld_d;
      strb_q    <= strb_d;
      launch_q  <= launch_d;
      busy_q    <= busy_d;
    end
  end

`ifdef CHIPPER_INJ_HIZ_EN
  assign inc = inc_vld_q ? inc_q : {DATA_W{1'bz}};
`else
  assign inc = inc_vld_q ? inc_q : '0;
`endif

  assign nsig       = strb_q[0];
  assign ssig       = strb_q[1];
  assign esig       = strb_q[2];
  assign wsig       = strb_q[3];
  assign clksig     = launch_q;
  assign frame_done = launch_q;
  assign busy       = busy_q;
  assign occ        = occ_q;

endmodule

// File: tb/tb_chipper_flit_injector.sv
// Directed bench for chipper_flit_injector (default build, SETUP_CYC=1) plus an AUTO_LAUNCH instance.
module tb_chipper_flit_injector;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, launch_req, cachemiss, al_valid;
  logic [1:0] in_port;
  logic [6:0] in_data;

  logic       in_ready, nsig, ssig, esig, wsig, clksig, busy, frame_done;
  logic [6:0] inc;
  logic [3:0] occ;

  logic       al_ready, al_nsig, al_ssig, al_esig, al_wsig, al_clksig, al_busy, al_done;
  logic [6:0] al_inc;
  logic [3:0] al_occ;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  chipper_flit_injector #(.DATA_W(7), .SETUP_CYC(1), .AUTO_LAUNCH(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_port(in_port),
    .in_data(in_data), .launch_req(launch_req), .cachemiss(cachemiss), .inc(inc),
    .nsig(nsig), .ssig(ssig), .esig(esig), .wsig(wsig), .clksig(clksig), .busy(busy),
    .frame_done(frame_done), .occ(occ)
  );

  chipper_flit_injector #(.DATA_W(7), .SETUP_CYC(1), .AUTO_LAUNCH(1)) dut_al (
    .clk(clk), .rst(rst), .in_valid(al_valid), .in_ready(al_ready), .in_port(in_port),
    .in_data(in_data), .launch_req(1'b0), .cachemiss(1'b0), .inc(al_inc),
    .nsig(al_nsig), .ssig(al_ssig), .esig(al_esig), .wsig(al_wsig), .clksig(al_clksig),
    .busy(al_busy), .frame_done(al_done), .occ(al_occ)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] p, input logic [6:0] d);
    in_valid = 1'b1;
    in_port  = p;
    in_data  = d;
    #1;
    check($sformatf("load_ready p%0d", p), 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // launch_req in cycle 0 (plus an optional same-cycle write); cachemiss is seen
  // at edges stall_edge .. stall_edge+stall_len-1; cn..cc are the expected pulse cycles.
  task automatic run_frame(input logic [6:0] en, input logic [6:0] es, input logic [6:0] ee,
                           input logic [6:0] ew, input logic wr_en, input logic [1:0] wr_p,
                           input logic [6:0] wr_d, input int stall_edge, input int stall_len,
                           input int cn, input int cs, input int ce, input int cw, input int cc);
    launch_req = 1'b1;
    in_valid   = wr_en;
    in_port    = wr_p;
    in_data    = wr_d;
    cachemiss  = 1'b0;
    for (int k = 1; k <= cc + 1; k++) begin
      step();
      launch_req = 1'b0;
      in_valid   = 1'b0;
      cachemiss  = (stall_len > 0) && (k >= stall_edge - 1) && (k <= stall_edge + stall_len - 2);
      if (k == 1) begin
        in_valid = 1'b1;
        in_port  = 2'd1;
        in_data  = 7'h5a;
        #1;
        check("busy_write_refused", 32'(in_ready), 32'd0);
      end
      check($sformatf("pulses@%0d", k), 32'({nsig, ssig, esig, wsig, clksig, frame_done}),
            32'({k == cn, k == cs, k == ce, k == cw, k == cc, k == cc}));
      check($sformatf("busy@%0d", k), 32'(busy), 32'(k <= cc));
      if (k == cn) check("inc_n", 32'(inc), 32'(en));
      if (k == cs) check("inc_s", 32'(inc), 32'(es));
      if (k == ce) check("inc_e", 32'(inc), 32'(ee));
      if (k == cw) check("inc_w", 32'(inc), 32'(ew));
      if (k == cc) check("inc_launch", 32'(inc), 32'd0);
    end
    cachemiss = 1'b0;
    check("occ_after_frame", 32'(occ), 32'd0);
    in_port = 2'd0;
    #1;
    check("ready_after_frame", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; launch_req = 1'b0; cachemiss = 1'b0; al_valid = 1'b0;
    in_port = 2'd0; in_data = 7'd0;
    step(); step();
    rst = 1'b0;
    step();

    // mid-cycle reset clears everything at once
    load(2'd0, 7'h12);
    load(2'd2, 7'h34);
    check("occ_loaded", 32'(occ), 32'h5);
    #2 rst = 1'b1;
    #1;
    check("rst_outputs", 32'({inc, nsig, ssig, esig, wsig, clksig, busy, frame_done, occ}), 32'd0);
    for (int p = 0; p < 4; p++) begin
      in_port = 2'(p);
      #1;
      check($sformatf("rst_ready p%0d", p), 32'(in_ready), 32'd1);
    end
    step();
    rst = 1'b0;
    step();

    // full frame, nominal timing
    load(2'd0, 7'b0000101);
    load(2'd1, 7'b1100001);
    load(2'd2, 7'b0100100);
    load(2'd3, 7'b1100100);
    check("occ_full", 32'(occ), 32'hf);
    run_frame(7'b0000101, 7'b1100001, 7'b0100100, 7'b1100100, 1'b0, 2'd0, 7'd0,
              0, 0, 2, 4, 6, 8, 9);

    // only E, written in the same cycle as launch_req; other ports load null
    run_frame(7'd0, 7'd0, 7'b0111111, 7'd0, 1'b1, 2'd2, 7'b0111111, 0, 0, 2, 4, 6, 8, 9);

    // duplicate write to N is refused, first value kept
    load(2'd0, 7'h11);
    in_valid = 1'b1; in_port = 2'd0; in_data = 7'h22;
    #1;
    check("dup_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    check("dup_occ", 32'(occ), 32'h1);
    run_frame(7'h11, 7'd0, 7'd0, 7'd0, 1'b0, 2'd0, 7'd0, 0, 0, 2, 4, 6, 8, 9);

    // auto-launch once the fourth slot fills
    for (int p = 0; p < 4; p++) begin
      al_valid = 1'b1; in_port = 2'(p); in_data = 7'(p + 7'h40);
      step();
    end
    al_valid = 1'b0;
    check("al_busy", 32'({al_busy, al_occ}), 32'h1f);
    step();
    check("al_nsig", 32'({al_nsig, al_inc}), 32'({1'b1, 7'h40}));
    for (int k = 0; k < 7; k++) step();
    check("al_launch", 32'({al_clksig, al_done}), 32'h3);
    step();
    check("al_idle", 32'({al_busy, al_occ}), 32'd0);

    // cachemiss at edges 4..6 delays the S strobe and everything behind it
    load(2'd0, 7'h01);
    load(2'd1, 7'h02);
    load(2'd2, 7'h04);
    load(2'd3, 7'h08);
    run_frame(7'h01, 7'h02, 7'h04, 7'h08, 1'b0, 2'd0, 7'd0, 4, 3, 2, 7, 9, 11, 12);

    // reset during W_STB: no launch, slots dropped
    load(2'd0, 7'h33);
    load(2'd3, 7'h44);
    launch_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      launch_req = 1'b0;
    end
    check("w_stb_before_rst", 32'({wsig, inc}), 32'({1'b1, 7'h44}));
    #2 rst = 1'b1;
    #1;
    check("w_rst_async", 32'({wsig, clksig, busy, occ, inc}), 32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("no_launch_after_rst@%0d", k), 32'({clksig, frame_done, busy, occ}), 32'd0);
    end
    for (int p = 0; p < 4; p++) begin
      in_port = 2'(p);
      #1;
      check($sformatf("ready_after_rst p%0d", p), 32'(in_ready), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
